// File: rtl/dct_mult_pkg.sv
// rtl/dct_mult_pkg.sv - shared types, defaults and saturation limits for the DCT Booth multiplier
package dct_mult_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   localparam int DEF_W    = 16;
   localparam int DEF_FRAC = 15;

   // Callers truncate to their own width; the low w bits hold the limit.
   function automatic logic [63:0] sat_max(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_min(input int w);
      return ~sat_max(w);
   endfunction

endpackage

// File: rtl/booth_fixp_post.sv
// rtl/booth_fixp_post.sv - combinational round/slice/saturate of the 2W-bit Booth product
// Rounding (round half up) is enabled by defining BOOTH_ROUND_EN.
module booth_fixp_post
   import dct_mult_pkg::*;
#(
   parameter int W    = DEF_W,
   parameter int FRAC = W - 1,
   parameter int SAT  = 1
) (
   input  logic [2*W-1:0] P,
   output logic [W-1:0]   R,
   output logic           ovf
);

   localparam logic [W-1:0] LIM_MAX = W'(sat_max(W));
   localparam logic [W-1:0] LIM_MIN = W'(sat_min(W));

   logic signed [2*W-1:0] w_s;
   logic signed [2*W-1:0] w_shift;
   logic        [W-1:0]   w_slice;

`ifdef BOOTH_ROUND_EN
   if (FRAC == 0) begin : g_bad_frac
      $error("BOOTH_ROUND_EN requires FRAC >= 1");
   end
   assign w_s = P + ((2*W)'(1) << (FRAC - 1));
`else
   assign w_s = P;
`endif

   // The result fits iff the arithmetically shifted value equals the sign extension of its low W bits.
   assign w_shift = w_s >>> FRAC;
   assign w_slice = w_shift[W-1:0];
   assign ovf     = (w_shift != {{W{w_slice[W-1]}}, w_slice});

   always_comb begin
      R = w_slice;
      if ((SAT != 0) && ovf) begin
         R = w_s[2*W-1] ? LIM_MIN : LIM_MAX;
      end
   end

endmodule

// File: rtl/booth_fixp_multiplier.sv
// rtl/booth_fixp_multiplier.sv - iterative radix-2 Booth signed fixed-point multiplier, start/done handshake
// Optional rounding in the post-processor is selected by defining BOOTH_ROUND_EN.
module booth_fixp_multiplier
   import dct_mult_pkg::*;
#(
   parameter int W    = DEF_W,
   parameter int FRAC = W - 1,
   parameter int SAT  = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] R,
   output logic         ovf,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(W + 1);

   state_t         r_state;
   logic [W-1:0]   r_m;
   logic [W-1:0]   r_q;
   logic [W:0]     r_acc;
   logic           r_qm1;
   logic [CW-1:0]  r_cnt;

   logic [W:0]     w_m_ext;
   logic [W:0]     w_acc_sum;
   logic [W-1:0]   w_r;
   logic           w_ovf;

   // One extra accumulator bit keeps ACC - M exact when M is the most negative value.
   assign w_m_ext = {r_m[W-1], r_m};

   always_comb begin
      case ({r_q[0], r_qm1})
         2'b01:   w_acc_sum = r_acc + w_m_ext;
         2'b10:   w_acc_sum = r_acc - w_m_ext;
         default: w_acc_sum = r_acc;
      endcase
   end

   booth_fixp_post #(
      .W    (W),
      .FRAC (FRAC),
      .SAT  (SAT)
   ) u_post (
      .P   ({r_acc[W-1:0], r_q}),
      .R   (w_r),
      .ovf (w_ovf)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_m     <= '0;
         r_q     <= '0;
         r_acc   <= '0;
         r_qm1   <= 1'b0;
         r_cnt   <= '0;
         R       <= '0;
         ovf     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_m     <= A;
                  r_q     <= B;
                  r_acc   <= '0;
                  r_qm1   <= 1'b0;
                  r_cnt   <= CW'(W);
                  busy    <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc <= {w_acc_sum[W], w_acc_sum[W:1]};
               r_q   <= {w_acc_sum[0], r_q[W-1:1]};
               r_qm1 <= r_q[0];
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= S_FIN;
               end
            end
            S_FIN: begin
               R       <= w_r;
               ovf     <= w_ovf;
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_fixp_multiplier.sv
// tb/tb_booth_fixp_multiplier.sv - self-checking bench for booth_fixp_multiplier
module tb_booth_fixp_multiplier;

   localparam int F16 = 15;
   localparam int F8  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        st16 = 1'b0;
   logic        st8 = 1'b0;
   logic [15:0] a16 = '0;
   logic [15:0] b16 = '0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;

   logic [15:0] r_s, r_w;
   logic        ovf_s, ovf_w, busy_s, busy_w, done_s, done_w;
   logic [7:0]  r_8;
   logic        ovf_8, busy_8, done_8;

   int vecs = 0;
   int errs = 0;
   int dones_s = 0;
   int dones_8 = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done_s) dones_s <= dones_s + 1;
      if (done_8) dones_8 <= dones_8 + 1;
   end

   booth_fixp_multiplier #(.W(16), .FRAC(F16), .SAT(1)) u16s (
      .clk(clk), .rst(rst), .start(st16), .A(a16), .B(b16),
      .R(r_s), .ovf(ovf_s), .busy(busy_s), .done(done_s));

   booth_fixp_multiplier #(.W(16), .FRAC(F16), .SAT(0)) u16w (
      .clk(clk), .rst(rst), .start(st16), .A(a16), .B(b16),
      .R(r_w), .ovf(ovf_w), .busy(busy_w), .done(done_w));

   booth_fixp_multiplier #(.W(8), .FRAC(F8), .SAT(1)) u8 (
      .clk(clk), .rst(rst), .start(st8), .A(a8), .B(b8),
      .R(r_8), .ovf(ovf_8), .busy(busy_8), .done(done_8));

   // Reference: exact product, optional half-up rounding, floor shift, range check.
   function automatic void ref_mul(input int w, input int frac, input bit sat,
                                   input longint a, input longint b,
                                   output longint r, output bit o);
      longint p, q, mx, mn;
      p = a * b;
`ifdef BOOTH_ROUND_EN
      p = p + (longint'(1) <<< (frac - 1));
`endif
      q  = p >>> frac;
      mx = (longint'(1) <<< (w - 1)) - 1;
      mn = -mx - 1;
      o  = (q > mx) || (q < mn);
      if (o && sat) r = (q < 0) ? mn : mx;
      else          r = q;
      r = r & ((longint'(1) <<< w) - 1);
   endfunction

   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 7))
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         2:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   function automatic logic [7:0] rnd8();
      case ($urandom_range(0, 7))
         0:       return 8'h80;
         1:       return 8'h7F;
         2:       return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   // Issue one start on the 16-bit pair; lat = edges after the accepting edge until done, -1 on timeout.
   task automatic do16(input logic [15:0] a, input logic [15:0] b, output int lat);
      @(negedge clk);
      a16 = a; b16 = b; st16 = 1'b1;
      @(negedge clk);
      st16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      lat = 0;
      while (!done_s && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!done_s) lat = -1;
   endtask

   task automatic do8(input logic [7:0] a, input logic [7:0] b, output int lat);
      @(negedge clk);
      a8 = a; b8 = b; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 0;
      while (!done_8 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!done_8) lat = -1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vecs++;
      if ({r_s, ovf_s, busy_s, done_s} !== 19'd0) begin
         errs++; $display("FAIL reset_u16s got %h want 0", {r_s, ovf_s, busy_s, done_s});
      end
      vecs++;
      if ({r_w, ovf_w, busy_w, done_w} !== 19'd0) begin
         errs++; $display("FAIL reset_u16w got %h want 0", {r_w, ovf_w, busy_w, done_w});
      end
      vecs++;
      if ({r_8, ovf_8, busy_8, done_8} !== 11'd0) begin
         errs++; $display("FAIL reset_u8 got %h want 0", {r_8, ovf_8, busy_8, done_8});
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_directed();
      logic [15:0] ta [4];
      logic [15:0] tbv [4];
      int lat;
      longint er, erw;
      bit eo, eow;
      ta  = '{16'h4000, 16'h7FFF, 16'h8000, 16'h0001};
      tbv = '{16'h4000, 16'h8000, 16'h8000, 16'h4000};
      for (int i = 0; i < 4; i++) begin
         do16(ta[i], tbv[i], lat);
         ref_mul(16, F16, 1'b1, longint'($signed(ta[i])), longint'($signed(tbv[i])), er, eo);
         ref_mul(16, F16, 1'b0, longint'($signed(ta[i])), longint'($signed(tbv[i])), erw, eow);
         vecs++;
         if (lat !== 17) begin
            errs++; $display("FAIL dir%0d_latency got %0d want 17", i, lat);
         end
         vecs++;
         if ({r_s, ovf_s} !== {16'(er), eo}) begin
            errs++; $display("FAIL dir%0d_sat got R=%h ovf=%b want R=%h ovf=%b", i, r_s, ovf_s, 16'(er), eo);
         end
         vecs++;
         if ({r_w, ovf_w, done_w} !== {16'(erw), eow, 1'b1}) begin
            errs++; $display("FAIL dir%0d_wrap got R=%h ovf=%b done=%b want R=%h ovf=%b done=1",
                             i, r_w, ovf_w, done_w, 16'(erw), eow);
         end
      end
   endtask

   task automatic test_ignore_start();
      int n, d0;
      @(negedge clk);
      a16 = 16'h4000; b16 = 16'h4000; st16 = 1'b1;
      @(negedge clk);
      st16 = 1'b0;
      n = 0;
      repeat (4) begin @(negedge clk); n++; end
      vecs++;
      if (busy_s !== 1'b1) begin
         errs++; $display("FAIL busy_in_run got %b want 1", busy_s);
      end
      a16 = 16'h7FFF; b16 = 16'h7FFF; st16 = 1'b1;
      @(negedge clk);
      n++;
      st16 = 1'b0;
      while (!done_s && n < 200) begin @(negedge clk); n++; end
      vecs++;
      if ({n, r_s, ovf_s} !== {32'd17, 16'h2000, 1'b0}) begin
         errs++; $display("FAIL ignore_start got lat=%0d R=%h ovf=%b want lat=17 R=2000 ovf=0", n, r_s, ovf_s);
      end
      @(negedge clk);
      d0 = dones_s;
      repeat (24) @(negedge clk);
      vecs++;
      if ({dones_s - d0, busy_s} !== {32'd0, 1'b0}) begin
         errs++; $display("FAIL ignore_no_queue got extra_done=%0d busy=%b want 0 0", dones_s - d0, busy_s);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] a1, b1, a2, b2;
      int lat, n;
      longint e1, e2;
      bit o1, o2;
      a1 = rnd16(); b1 = rnd16(); a2 = rnd16(); b2 = rnd16();
      ref_mul(16, F16, 1'b1, longint'($signed(a1)), longint'($signed(b1)), e1, o1);
      ref_mul(16, F16, 1'b1, longint'($signed(a2)), longint'($signed(b2)), e2, o2);
      do16(a1, b1, lat);
      vecs++;
      if ({lat, r_s, ovf_s} !== {32'd17, 16'(e1), o1}) begin
         errs++; $display("FAIL b2b_first got lat=%0d R=%h ovf=%b want lat=17 R=%h ovf=%b", lat, r_s, ovf_s, 16'(e1), o1);
      end
      a16 = a2; b16 = b2; st16 = 1'b1;
      @(negedge clk);
      st16 = 1'b0;
      n = 0;
      while (!done_s && n < 200) begin @(negedge clk); n++; end
      vecs++;
      if ({n, r_s, ovf_s} !== {32'd17, 16'(e2), o2}) begin
         errs++; $display("FAIL b2b_second got lat=%0d R=%h ovf=%b want lat=17 R=%h ovf=%b", n, r_s, ovf_s, 16'(e2), o2);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      longint er;
      bit eo;
      do16(16'h8000, 16'h8000, lat);
      @(negedge clk);
      a16 = 16'h7FFF; b16 = 16'h7FFF; st16 = 1'b1;
      @(negedge clk);
      st16 = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b0;
      #1;
      vecs++;
      if ({r_s, ovf_s, busy_s, done_s} !== 19'd0) begin
         errs++; $display("FAIL reset_mid got R=%h ovf=%b busy=%b done=%b want all 0", r_s, ovf_s, busy_s, done_s);
      end
      @(negedge clk);
      rst = 1'b1;
      do16(16'h6000, 16'hB000, lat);
      ref_mul(16, F16, 1'b1, longint'($signed(16'h6000)), longint'($signed(16'hB000)), er, eo);
      vecs++;
      if ({lat, r_s, ovf_s} !== {32'd17, 16'(er), eo}) begin
         errs++; $display("FAIL after_reset got lat=%0d R=%h ovf=%b want lat=17 R=%h ovf=%b", lat, r_s, ovf_s, 16'(er), eo);
      end
   endtask

   task automatic test_random();
      int lat, d0s, d08, n16, n8;
      logic [15:0] a, b;
      logic [7:0] c, d;
      longint er, erw;
      bit eo, eow;
      @(negedge clk);
      d0s = dones_s; d08 = dones_8; n16 = 0; n8 = 0;
      for (int i = 0; i < 150; i++) begin
         a = rnd16(); b = rnd16();
         ref_mul(16, F16, 1'b1, longint'($signed(a)), longint'($signed(b)), er, eo);
         ref_mul(16, F16, 1'b0, longint'($signed(a)), longint'($signed(b)), erw, eow);
         do16(a, b, lat);
         n16++;
         vecs++;
         if ({lat, r_s, ovf_s, r_w, ovf_w} !== {32'd17, 16'(er), eo, 16'(erw), eow}) begin
            errs++; $display("FAIL rnd16 A=%h B=%h got lat=%0d R=%h/%h ovf=%b/%b want lat=17 R=%h/%h ovf=%b/%b",
                             a, b, lat, r_s, r_w, ovf_s, ovf_w, 16'(er), 16'(erw), eo, eow);
         end
      end
      for (int i = 0; i < 250; i++) begin
         c = rnd8(); d = rnd8();
         ref_mul(8, F8, 1'b1, longint'($signed(c)), longint'($signed(d)), er, eo);
         do8(c, d, lat);
         n8++;
         vecs++;
         if ({lat, r_8, ovf_8} !== {32'd9, 8'(er), eo}) begin
            errs++; $display("FAIL rnd8 A=%h B=%h got lat=%0d R=%h ovf=%b want lat=9 R=%h ovf=%b",
                             c, d, lat, r_8, ovf_8, 8'(er), eo);
         end
      end
      @(negedge clk);
      @(negedge clk);
      vecs++;
      if ({dones_s - d0s, dones_8 - d08} !== {n16, n8}) begin
         errs++; $display("FAIL done_count got %0d/%0d want %0d/%0d", dones_s - d0s, dones_8 - d08, n16, n8);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
